// File: rtl/mouse_cursor_tracker_pkg.sv
// mouse_pkg: shared FSM state type, PS/2 header bit positions and default
// canvas geometry for mouse_cursor_tracker.
package mouse_pkg;

  typedef enum logic [1:0] {
    B0,
    B1,
    B2,
    UPDATE
  } state_t;

  // PS/2 movement packet header byte layout
  localparam int unsigned HDR_BTN_L  = 0;
  localparam int unsigned HDR_BTN_R  = 1;
  localparam int unsigned HDR_SYNC   = 3;
  localparam int unsigned HDR_X_SIGN = 4;
  localparam int unsigned HDR_Y_SIGN = 5;
  localparam int unsigned HDR_X_OVF  = 6;
  localparam int unsigned HDR_Y_OVF  = 7;

  // Only the header fields the tracker consumes are kept
  typedef struct packed {
    logic yOvf;
    logic xOvf;
    logic ySign;
    logic xSign;
    logic btnR;
    logic btnL;
  } hdr_t;

  localparam int unsigned DEF_CANVAS_W = 28;
  localparam int unsigned DEF_CANVAS_H = 28;

endpackage

// File: rtl/mouse_axis_update.sv
// mouse_axis_update: one cursor axis. Sign-extends the 9-bit PS/2 delta,
// zeroes it on overflow, attenuates by an arithmetic right shift and adds
// (or subtracts, NEGATE=1) it to the current position, clamped to the canvas.
module mouse_axis_update
  import mouse_pkg::*;
#(
  parameter int unsigned SIZE   = DEF_CANVAS_W,
  parameter int unsigned SHIFT  = 2,
  parameter bit          NEGATE = 1'b0
) (
  input  logic [4:0] iPos,
  input  logic       iSign,
  input  logic [7:0] iMag,
  input  logic       iOvf,
  output logic [4:0] oPos
);

  localparam logic signed [11:0] MAX_POS = 12'(SIZE - 1);

  logic signed [8:0]  raw;
  logic signed [8:0]  shifted;
  logic signed [8:0]  delta;
  logic signed [11:0] deltaExt;
  logic signed [11:0] posExt;
  logic signed [11:0] sum;

  // Signed position arithmetic followed by clamp to [0, SIZE-1]
  always_comb begin
    raw      = {iSign, iMag};
    shifted  = raw >>> SHIFT;
    delta    = iOvf ? '0 : shifted;
    deltaExt = {{3{delta[8]}}, delta};
    posExt   = {7'b0, iPos};
    sum      = NEGATE ? (posExt - deltaExt) : (posExt + deltaExt);
    if (sum < 12'sd0) begin
      oPos = '0;
    end else if (sum > MAX_POS) begin
      oPos = MAX_POS[4:0];
    end else begin
      oPos = sum[4:0];
    end
  end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: assembles 3-byte PS/2 mouse packets, moves a cursor
// on a small canvas and paints under it while the left button is held.
// Optional feature: define MOUSE_ERASE_EN to let the right button erase.
module mouse_cursor_tracker
  import mouse_pkg::*;
#(
  parameter int unsigned CANVAS_W = DEF_CANVAS_W,
  parameter int unsigned CANVAS_H = DEF_CANVAS_H,
  parameter int unsigned SHIFT    = 2,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iByte,
  input  logic       iByteValid,
  input  logic       iParityErr,
  output logic [4:0] oCursorX,
  output logic [4:0] oCursorY,
  output logic       oBtnL,
  output logic       oBtnR,
  output logic       oPixWe,
  output logic [9:0] oPixAddr,
  output logic       oPixData,
  output logic       oPktValid,
  output logic       oSyncErr
);

  localparam int unsigned     GAP_W    = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  state_t           state;
  state_t           nextState;
  hdr_t             hdr;
  logic [7:0]       dxByte;
  logic [7:0]       dyByte;
  logic [GAP_W-1:0] gapCnt;
  logic             gapExpired;
  logic             latchHdr;
  logic             latchDx;
  logic             latchDy;
  logic             syncErrNext;
  logic             apply;
  logic [4:0]       newX;
  logic [4:0]       newY;
  logic             wrNext;
  logic             pixDataNext;

  // gapExpired is true on the TIMEOUT-th consecutive idle cycle
  assign gapExpired = (gapCnt == GAP_LAST);

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= B0;
    end else begin
      state <= nextState;
    end
  end

  // Packet framing: next state, byte latch enables and sync-error strobe
  always_comb begin
    nextState   = state;
    latchHdr    = 1'b0;
    latchDx     = 1'b0;
    latchDy     = 1'b0;
    syncErrNext = 1'b0;
    apply       = 1'b0;
    unique case (state)
      B0: begin
        if (iByteValid) begin
          if (iByte[HDR_SYNC] && !iParityErr) begin
            latchHdr  = 1'b1;
            nextState = B1;
          end else begin
            syncErrNext = 1'b1;
          end
        end
      end
      B1: begin
        if (iByteValid) begin
          if (iParityErr) begin
            syncErrNext = 1'b1;
            nextState   = B0;
          end else begin
            latchDx   = 1'b1;
            nextState = B2;
          end
        end else if (gapExpired) begin
          syncErrNext = 1'b1;
          nextState   = B0;
        end
      end
      B2: begin
        if (iByteValid) begin
          if (iParityErr) begin
            syncErrNext = 1'b1;
            nextState   = B0;
          end else begin
            latchDy   = 1'b1;
            nextState = UPDATE;
          end
        end else if (gapExpired) begin
          syncErrNext = 1'b1;
          nextState   = B0;
        end
      end
      UPDATE: begin
        apply       = 1'b1;
        nextState   = B0;
        syncErrNext = iByteValid;
      end
      default: nextState = B0;
    endcase
  end

  // Idle byte-gap counter, only counts while mid-packet
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      gapCnt <= '0;
    end else if ((state == B1 || state == B2) && !iByteValid && !gapExpired) begin
      gapCnt <= gapCnt + 1'b1;
    end else begin
      gapCnt <= '0;
    end
  end

  // Packet byte latches
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hdr    <= '0;
      dxByte <= '0;
      dyByte <= '0;
    end else begin
      if (latchHdr) begin
        hdr.btnL  <= iByte[HDR_BTN_L];
        hdr.btnR  <= iByte[HDR_BTN_R];
        hdr.xSign <= iByte[HDR_X_SIGN];
        hdr.ySign <= iByte[HDR_Y_SIGN];
        hdr.xOvf  <= iByte[HDR_X_OVF];
        hdr.yOvf  <= iByte[HDR_Y_OVF];
      end
      if (latchDx) begin
        dxByte <= iByte;
      end
      if (latchDy) begin
        dyByte <= iByte;
      end
    end
  end

  mouse_axis_update #(
    .SIZE  (CANVAS_W),
    .SHIFT (SHIFT),
    .NEGATE(1'b0)
  ) uAxisX (
    .iPos (oCursorX),
    .iSign(hdr.xSign),
    .iMag (dxByte),
    .iOvf (hdr.xOvf),
    .oPos (newX)
  );

  // Screen rows grow downward while PS/2 dy grows upward
  mouse_axis_update #(
    .SIZE  (CANVAS_H),
    .SHIFT (SHIFT),
    .NEGATE(1'b1)
  ) uAxisY (
    .iPos (oCursorY),
    .iSign(hdr.ySign),
    .iMag (dyByte),
    .iOvf (hdr.yOvf),
    .oPos (newY)
  );

`ifdef MOUSE_ERASE_EN
  // Left paints, right alone erases; left wins when both are held
  assign wrNext      = hdr.btnL | hdr.btnR;
  assign pixDataNext = (apply && wrNext) ? hdr.btnL : oPixData;
`else
  assign wrNext      = hdr.btnL;
  assign pixDataNext = 1'b1;
`endif

  // Cursor, buttons and strobes commit on the edge leaving UPDATE
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oCursorX  <= 5'(CANVAS_W / 2);
      oCursorY  <= 5'(CANVAS_H / 2);
      oBtnL     <= 1'b0;
      oBtnR     <= 1'b0;
      oPixWe    <= 1'b0;
      oPixData  <= 1'b0;
      oPktValid <= 1'b0;
      oSyncErr  <= 1'b0;
    end else begin
      oPktValid <= apply;
      oSyncErr  <= syncErrNext;
      oPixWe    <= apply & wrNext;
      oPixData  <= pixDataNext;
      if (apply) begin
        oCursorX <= newX;
        oCursorY <= newY;
        oBtnL    <= hdr.btnL;
        oBtnR    <= hdr.btnR;
      end
    end
  end

  assign oPixAddr = 10'((32'(oCursorY) * CANVAS_W) + 32'(oCursorX));

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb_mouse_cursor_tracker: directed and randomized packet stimulus checked
// against an integer-arithmetic model of cursor movement.
`timescale 1ns/1ps
module tb_mouse_cursor_tracker;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int SH = 2;
  localparam int TO = 40;

  logic       iClk       = 1'b0;
  logic       iRst_n     = 1'b1;
  logic [7:0] iByte      = '0;
  logic       iByteValid = 1'b0;
  logic       iParityErr = 1'b0;
  logic [4:0] oCursorX;
  logic [4:0] oCursorY;
  logic       oBtnL;
  logic       oBtnR;
  logic       oPixWe;
  logic [9:0] oPixAddr;
  logic       oPixData;
  logic       oPktValid;
  logic       oSyncErr;

  int checks   = 0;
  int errors   = 0;
  int syncSeen = 0;
  int pktSeen  = 0;
  int mX = 14;
  int mY = 14;
  logic mL = 1'b0;
  logic mR = 1'b0;

  mouse_cursor_tracker #(
    .CANVAS_W(W),
    .CANVAS_H(H),
    .SHIFT   (SH),
    .TIMEOUT (TO)
  ) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iByte     (iByte),
    .iByteValid(iByteValid),
    .iParityErr(iParityErr),
    .oCursorX  (oCursorX),
    .oCursorY  (oCursorY),
    .oBtnL     (oBtnL),
    .oBtnR     (oBtnR),
    .oPixWe    (oPixWe),
    .oPixAddr  (oPixAddr),
    .oPixData  (oPixData),
    .oPktValid (oPktValid),
    .oSyncErr  (oSyncErr)
  );

  always #5 iClk = ~iClk;

  // Pulse counters sampled shortly after each active edge
  always @(posedge iClk) begin
    #2;
    if (oSyncErr === 1'b1) syncSeen++;
    if (oPktValid === 1'b1) pktSeen++;
  end

  function automatic int floor_div(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_packet(input logic [7:0] h, input logic [7:0] b1, input logic [7:0] b2);
    int dx;
    int dy;
    dx = h[6] ? 0 : floor_div(h[4] ? int'(b1) - 256 : int'(b1), 1 << SH);
    dy = h[7] ? 0 : floor_div(h[5] ? int'(b2) - 256 : int'(b2), 1 << SH);
    mX = clampi(mX + dx, 0, W - 1);
    mY = clampi(mY - dy, 0, H - 1);
    mL = h[0];
    mR = h[1];
  endtask

  task automatic model_reset();
    mX = W / 2;
    mY = H / 2;
    mL = 1'b0;
    mR = 1'b0;
  endtask

  function automatic logic exp_we();
`ifdef MOUSE_ERASE_EN
    return mL | mR;
`else
    return mL;
`endif
  endfunction

  function automatic logic exp_data();
`ifdef MOUSE_ERASE_EN
    return mL;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input logic [7:0] b, input logic perr);
    @(negedge iClk);
    iByte      = b;
    iByteValid = 1'b1;
    iParityErr = perr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      iByteValid = 1'b0;
      iParityErr = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 iRst_n = 1'b0;
    #3;
    checks++;
    if (oCursorX !== 5'd14 || oCursorY !== 5'd14 || oPixAddr !== 10'd406) begin
      errors++;
      $display("FAIL reset_pos: got x=%0d y=%0d addr=%0d, want 14 14 406", oCursorX, oCursorY, oPixAddr);
    end
    checks++;
    if ({oBtnL, oBtnR, oPixWe, oPixData, oPktValid, oSyncErr} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got L%b R%b we%b d%b pv%b se%b, want all 0",
               oBtnL, oBtnR, oPixWe, oPixData, oPktValid, oSyncErr);
    end
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge iClk);
    checks++;
    if (oCursorX !== 5'd14 || oCursorY !== 5'd14 || oPktValid !== 1'b0 || oSyncErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got x=%0d y=%0d pv=%b se=%b, want 14 14 0 0", oCursorX, oCursorY, oPktValid, oSyncErr);
    end
  endtask

  task automatic test_directed();
    logic [7:0] vh  [4] = '{8'h09, 8'h48, 8'h18, 8'h08};
    logic [7:0] vb1 [4] = '{8'h08, 8'h40, 8'h80, 8'h7F};
    logic [7:0] vb2 [4] = '{8'h04, 8'h04, 8'h00, 8'h00};
    int ex [4] = '{16, 16, 0, 27};
    int ey [4] = '{13, 12, 12, 12};
    logic el [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(vh[i], 1'b0);
      drive(vb1[i], 1'b0);
      drive(vb2[i], 1'b0);
      idle(1);
      checks++;
      if (oPktValid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early: pktValid=%b one cycle after last byte, want 0", i, oPktValid);
      end
      @(negedge iClk);
      checks++;
      if (oPktValid !== 1'b1 || oCursorX !== 5'(ex[i]) || oCursorY !== 5'(ey[i]) || oBtnL !== el[i] ||
          oPixWe !== el[i] || oPixAddr !== 10'(ey[i] * W + ex[i])) begin
        errors++;
        $display("FAIL dir%0d: got pv=%b x=%0d y=%0d L=%b we=%b addr=%0d, want 1 %0d %0d %b %b %0d",
                 i, oPktValid, oCursorX, oCursorY, oBtnL, oPixWe, oPixAddr,
                 ex[i], ey[i], el[i], el[i], ey[i] * W + ex[i]);
      end
      if (el[i]) begin
        checks++;
        if (oPixData !== 1'b1) begin
          errors++;
          $display("FAIL dir%0d_data: got %b want 1", i, oPixData);
        end
      end
      model_packet(vh[i], vb1[i], vb2[i]);
    end
  endtask

  task automatic test_sync_junk();
    int s0;
    s0 = syncSeen;
    drive(8'h00, 1'b0);
    idle(1);
    checks++;
    if (oSyncErr !== 1'b1) begin
      errors++;
      $display("FAIL sync_junk: syncErr=%b after header without bit3, want 1", oSyncErr);
    end
    drive(8'h08, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
    idle(2);
    model_packet(8'h08, 8'h00, 8'h00);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || oPixWe !== 1'b0 ||
        syncSeen - s0 != 1) begin
      errors++;
      $display("FAIL sync_recover: got pv=%b x=%0d y=%0d we=%b syncPulses=%0d, want 1 %0d %0d 0 1",
               oPktValid, oCursorX, oCursorY, oPixWe, syncSeen - s0, mX, mY);
    end
  endtask

  task automatic test_parity();
    int s0;
    s0 = syncSeen;
    drive(8'h09, 1'b1);
    idle(1);
    checks++;
    if (oSyncErr !== 1'b1) begin
      errors++;
      $display("FAIL parity_b0: syncErr=%b, want 1", oSyncErr);
    end
    drive(8'h08, 1'b0);
    drive(8'h10, 1'b1);
    idle(1);
    checks++;
    if (oSyncErr !== 1'b1) begin
      errors++;
      $display("FAIL parity_b1: syncErr=%b, want 1", oSyncErr);
    end
    drive(8'h08, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    idle(2);
    model_packet(8'h08, 8'h04, 8'h00);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || syncSeen - s0 != 2) begin
      errors++;
      $display("FAIL parity_recover: got pv=%b x=%0d y=%0d syncPulses=%0d, want 1 %0d %0d 2",
               oPktValid, oCursorX, oCursorY, syncSeen - s0, mX, mY);
    end
  endtask

  task automatic test_update_drop();
    int s0;
    int p0;
    s0 = syncSeen;
    p0 = pktSeen;
    drive(8'h08, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h0B, 1'b0);
    idle(1);
    model_packet(8'h08, 8'h04, 8'h00);
    checks++;
    if (oPktValid !== 1'b1 || oSyncErr !== 1'b1 || oCursorX !== 5'(mX)) begin
      errors++;
      $display("FAIL update_drop: got pv=%b se=%b x=%0d, want 1 1 %0d", oPktValid, oSyncErr, oCursorX, mX);
    end
    idle(2);
    drive(8'h08, 1'b0);
    drive(8'h00, 1'b0);
    drive(8'h04, 1'b0);
    idle(2);
    model_packet(8'h08, 8'h00, 8'h04);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || oBtnL !== 1'b0 ||
        pktSeen - p0 != 2 || syncSeen - s0 != 1) begin
      errors++;
      $display("FAIL update_drop_next: got pv=%b x=%0d y=%0d L=%b pkts=%0d syncs=%0d, want 1 %0d %0d 0 2 1",
               oPktValid, oCursorX, oCursorY, oBtnL, pktSeen - p0, syncSeen - s0, mX, mY);
    end
  endtask

  task automatic test_timeout();
    int  s0;
    int  k;
    logic seen;
    s0   = syncSeen;
    k    = 0;
    seen = 1'b0;
    drive(8'h08, 1'b0);
    drive(8'h10, 1'b0);
    idle(1);
    for (int i = 1; i <= TO + 10 && !seen; i++) begin
      @(negedge iClk);
      if (oSyncErr === 1'b1) begin
        seen = 1'b1;
        k    = i;
      end
    end
    checks++;
    if (!seen || k != TO) begin
      errors++;
      $display("FAIL timeout_at: syncErr seen=%b after %0d idle cycles, want after %0d", seen, k, TO);
    end
    drive(8'h08, 1'b0);
    drive(8'h10, 1'b0);
    drive(8'h04, 1'b0);
    idle(2);
    model_packet(8'h08, 8'h10, 8'h04);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || syncSeen - s0 != 1) begin
      errors++;
      $display("FAIL timeout_recover: got pv=%b x=%0d y=%0d syncs=%0d, want 1 %0d %0d 1",
               oPktValid, oCursorX, oCursorY, syncSeen - s0, mX, mY);
    end
  endtask

  task automatic test_gap_tolerance();
    int s0;
    s0 = syncSeen;
    drive(8'h08, 1'b0);
    idle(TO - 1);
    drive(8'hF8, 1'b0);
    idle(TO - 1);
    drive(8'h08, 1'b0);
    idle(2);
    model_packet(8'h08, 8'hF8, 8'h08);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || syncSeen != s0) begin
      errors++;
      $display("FAIL gap_tolerance: got pv=%b x=%0d y=%0d syncs=%0d, want 1 %0d %0d 0",
               oPktValid, oCursorX, oCursorY, syncSeen - s0, mX, mY);
    end
  endtask

  task automatic test_random();
    logic [7:0] h;
    logic [7:0] b1;
    logic [7:0] b2;
    int s0;
    for (int p = 0; p < 40; p++) begin
      h  = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      s0 = syncSeen;
      drive(h, 1'b0);
      idle(int'($urandom_range(0, 3)));
      drive(b1, 1'b0);
      idle(int'($urandom_range(0, 3)));
      drive(b2, 1'b0);
      idle(1);
      checks++;
      if (oPktValid !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_early: pktValid=%b, want 0", p, oPktValid);
      end
      @(negedge iClk);
      model_packet(h, b1, b2);
      checks++;
      if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || oBtnL !== mL ||
          oBtnR !== mR || oPixWe !== exp_we() || oPixAddr !== 10'(mY * W + mX) || syncSeen != s0) begin
        errors++;
        $display("FAIL rand%0d pkt %h %h %h: got pv=%b x=%0d y=%0d L=%b R=%b we=%b addr=%0d se=%0d, want 1 %0d %0d %b %b %b %0d 0",
                 p, h, b1, b2, oPktValid, oCursorX, oCursorY, oBtnL, oBtnR, oPixWe, oPixAddr,
                 syncSeen - s0, mX, mY, mL, mR, exp_we(), mY * W + mX);
      end
      if (exp_we()) begin
        checks++;
        if (oPixData !== exp_data()) begin
          errors++;
          $display("FAIL rand%0d_data: got %b want %b", p, oPixData, exp_data());
        end
      end
    end
  endtask

  task automatic test_reset_midpacket();
    int p0;
    p0 = pktSeen;
    drive(8'h09, 1'b0);
    drive(8'h7F, 1'b0);
    idle(1);
    #2 iRst_n = 1'b0;
    #1;
    checks++;
    if (oCursorX !== 5'd14 || oCursorY !== 5'd14 || oPixAddr !== 10'd406 ||
        {oBtnL, oBtnR, oPixWe, oPixData, oPktValid, oSyncErr} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_async: got x=%0d y=%0d addr=%0d flags=%b, want 14 14 406 000000",
               oCursorX, oCursorY, oPixAddr, {oBtnL, oBtnR, oPixWe, oPixData, oPktValid, oSyncErr});
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
    idle(4);
    drive(8'h08, 1'b0);
    drive(8'h04, 1'b0);
    drive(8'h00, 1'b0);
    idle(2);
    model_packet(8'h08, 8'h04, 8'h00);
    checks++;
    if (oPktValid !== 1'b1 || oCursorX !== 5'(mX) || oCursorY !== 5'(mY) || oPixWe !== 1'b0 ||
        pktSeen - p0 != 1) begin
      errors++;
      $display("FAIL midreset_next: got pv=%b x=%0d y=%0d we=%b pkts=%0d, want 1 %0d %0d 0 1",
               oPktValid, oCursorX, oCursorY, oPixWe, pktSeen - p0, mX, mY);
    end
  endtask

  task automatic test_erase();
    logic [7:0] eh [2] = '{8'h0A, 8'h0B};
    @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      drive(eh[i], 1'b0);
      drive(8'h00, 1'b0);
      drive(8'h00, 1'b0);
      idle(2);
      model_packet(eh[i], 8'h00, 8'h00);
      checks++;
      if (oPktValid !== 1'b1 || oBtnR !== 1'b1 || oBtnL !== mL || oPixWe !== exp_we() ||
          oPixAddr !== 10'd406) begin
        errors++;
        $display("FAIL erase%0d: got pv=%b R=%b L=%b we=%b addr=%0d, want 1 1 %b %b 406",
                 i, oPktValid, oBtnR, oBtnL, oPixWe, oPixAddr, mL, exp_we());
      end
      if (exp_we()) begin
        checks++;
        if (oPixData !== exp_data()) begin
          errors++;
          $display("FAIL erase%0d_data: got %b want %b", i, oPixData, exp_data());
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_sync_junk();
    test_parity();
    test_update_drop();
    test_timeout();
    test_gap_tolerance();
    test_random();
    test_reset_midpacket();
    test_erase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_tracker.md
MOUSE_CURSOR_TRACKER -- requirements
Module: mouse_cursor_tracker

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  CANVAS_W  28    canvas width in pixels
  CANVAS_H  28    canvas height in pixels
  SHIFT     2     movement attenuation, arithmetic right-shift applied to dx/dy
  TIMEOUT   50000 maximum iClk cycles allowed between bytes of one packet
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  iClk        in   1   system clock
  iRst_n      in   1   reset, asynchronous, active-low
  iByte       in   8   received PS/2 data byte
  iByteValid  in   1   one-cycle strobe; iByte is valid
  iParityErr  in   1   qualifies iByteValid; byte failed parity
  oCursorX    out  5   cursor column
  oCursorY    out  5   cursor row, 0 = top
  oBtnL       out  1   left button state
  oBtnR       out  1   right button state
  oPixWe      out  1   one-cycle canvas write strobe
  oPixAddr    out  10  canvas address, equal to oCursorY*CANVAS_W+oCursorX
  oPixData    out  1   canvas write value
  oPktValid   out  1   one-cycle strobe; complete packet applied
  oSyncErr    out  1   one-cycle strobe; byte discarded or packet aborted

Function
REQ-003 SHALL implement states: B0, B1, B2, UPDATE.
REQ-004 B0: on iByteValid with bit3=1 and no parity error, SHALL latch the header and go to B1; otherwise SHALL stay in B0 and pulse oSyncErr.
REQ-005 B1 and B2: on a valid byte, SHALL latch it as dx (B1) or dy (B2) and advance; B2 advances to UPDATE.
REQ-006 On iParityErr in B1 or B2, SHALL return to B0 and pulse oSyncErr.
REQ-007 An idle byte-gap counter SHALL run in B1 and B2; when it reaches TIMEOUT, the block SHALL return to B0 and pulse oSyncErr.
REQ-008 dx SHALL be the 9-bit signed value {hdr[4],byte1}; dy SHALL be {hdr[5],byte2}; each SHALL be arithmetic-shifted right by SHIFT.
REQ-009 If hdr[6] (X overflow) or hdr[7] (Y overflow) is set, the movement on that axis SHALL be zero.
REQ-010 In UPDATE: newX = clamp(X+dx, 0, CANVAS_W-1); newY = clamp(Y-dy, 0, CANVAS_H-1). Y is inverted. Intermediate arithmetic SHALL be signed at least 11 bits wide.
REQ-011 UPDATE SHALL last exactly one cycle and then go to B0. Cursor, buttons and oPktValid SHALL update on the clock edge that leaves UPDATE, i.e. 2 cycles after the third iByteValid.
REQ-012 oBtnL SHALL take hdr[0]; oBtnR SHALL take hdr[1].
REQ-013 oPixWe SHALL pulse in the same cycle as oPktValid when the new oBtnL=1, addressing the new cursor position, with oPixData=1.
REQ-014 iByteValid arriving while in UPDATE SHALL be dropped and SHALL pulse oSyncErr.

Reset
REQ-015 iRst_n low SHALL immediately force state B0, clear the gap counter, set oCursorX=CANVAS_W/2 and oCursorY=CANVAS_H/2 (14,14), and clear every strobe, oBtnL, oBtnR and oPixData. oPixAddr SHALL be 406.
REQ-016 A reset asserted mid-packet SHALL discard all partial bytes, with no write and no oPktValid.

Configuration
REQ-017 Macro MOUSE_ERASE_EN. When defined: if the new oBtnR=1 and oBtnL=0, oPixWe SHALL pulse with oPixData=0 (erase); if both buttons are 1, left wins. When undefined: the right button SHALL only be reported and oPixData SHALL be constant 1 (0 in reset).

Structure
REQ-018 Package mouse_pkg SHALL hold the state enum, the header bit indices (sync, sign, overflow, button) and the default canvas constants.
REQ-019 Sub-module mouse_axis_update SHALL perform sign-extend, overflow gating, shift and clamp. It SHALL be instanced once per axis, with Y negation selected by parameter.

Verification
REQ-020 Bytes 0x09, 0x08, 0x04 -> cursor (16,13), oBtnL=1, oPixWe=1, oPixAddr=380, oPktValid 2 cycles after the last byte.
REQ-021 Byte 0x00 in B0, then 0x08, 0x00, 0x00 -> one oSyncErr; then oPktValid; cursor stays (14,14); no write.
REQ-022 From (14,14), bytes 0x18, 0x80, 0x00 (dx=-128) -> X clamped to 0. Bytes 0x08, 0x7F, 0x00 -> X clamped to 27.
REQ-023 Bytes 0x08, 0x10, then no byte for TIMEOUT cycles -> oSyncErr; the next 3-byte packet is decoded correctly.
REQ-024 Bytes 0x48, 0x40, 0x04 (X overflow) -> X unchanged, Y decremented by 1.
REQ-025 With MOUSE_ERASE_EN: bytes 0x0A, 0x00, 0x00 -> oPixWe=1, oPixData=0, addr 406. Without the macro: no oPixWe.
